// File: rtl/snake_pkg.sv
// Shared types and constants for the snake game pixel path.
// Framebuffer geometry defaults and producer indices.
package snake_pkg;

  typedef enum logic {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int DEF_XW = 8;
  localparam int DEF_YW = 7;
  localparam int DEF_CW = 3;

  localparam int CLEAR = 0;
  localparam int SNAKE = 1;
  localparam int FOOD  = 2;

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Producer-side burst bus plus the shared VGA write port.
// The arbiter is the slave; producers and the VGA adapter face the master side.
interface vga_plot_arbiter_if #(
  parameter int NREQ = 3,
  parameter int XW   = 8,
  parameter int YW   = 7,
  parameter int CW   = 3
);

  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    last;
  logic [NREQ*XW-1:0] req_x;
  logic [NREQ*YW-1:0] req_y;
  logic [NREQ*CW-1:0] req_c;
  logic [NREQ-1:0]    grant;
  logic [XW-1:0]      x_out;
  logic [YW-1:0]      y_out;
  logic [CW-1:0]      colour_out;
  logic               plot;
  logic               busy;
  logic               timeout_err;

  modport slave (
    input  req, last, req_x, req_y, req_c,
    output grant, x_out, y_out, colour_out,
    output plot, busy, timeout_err
  );

  modport master (
    output req, last, req_x, req_y, req_c,
    input  grant, x_out, y_out, colour_out,
    input  plot, busy, timeout_err
  );

endinterface

// File: rtl/vga_plot_arbiter_rr_picker.sv
// Round-robin pick: first set request scanning circularly from ptr.
// Purely combinational; pick is one-hot, valid flags any request.
module rr_picker #(
  parameter int NREQ = 3,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic            valid
);

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!valid && req[(int'(ptr) + k) % NREQ]) begin
        pick[(int'(ptr) + k) % NREQ] = 1'b1;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Burst-level round-robin arbiter for the single VGA framebuffer write port.
// A watchdog releases the port when the owning producer stops sending.
module vga_plot_arbiter
  import snake_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int XW      = DEF_XW,
  parameter int YW      = DEF_YW,
  parameter int CW      = DEF_CW,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  vga_plot_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [CW-1:0]   c_q, c_d;
  logic            plot_q, plot_d;
  logic            terr_q, terr_d;

  logic [NREQ-1:0] pick;
  logic            pick_vld;
  logic [PW-1:0]   own;
  logic [PW-1:0]   own_nxt;
  logic            acc;
  logic            acc_last;

  rr_picker #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (bus.req),
    .ptr   (rr_q),
    .pick  (pick),
    .valid (pick_vld)
  );

  always_comb begin
    own = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) own = PW'(i);
    end
  end

  assign own_nxt  = (own == PW'(NREQ - 1)) ? '0 : own + PW'(1);
  assign acc      = |(grant_q & bus.req);
  assign acc_last = |(grant_q & bus.req & bus.last);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    wd_d    = wd_q;
    x_d     = x_q;
    y_d     = y_q;
    c_d     = c_q;
    plot_d  = 1'b0;
    terr_d  = 1'b0;
    unique case (state_q)
      ARB: begin
        wd_d = '0;
        if (pick_vld) begin
          grant_d = pick;
          state_d = BURST;
        end
      end
      BURST: begin
        if (acc) begin
          x_d    = bus.req_x[own*XW +: XW];
          y_d    = bus.req_y[own*YW +: YW];
          c_d    = bus.req_c[own*CW +: CW];
          plot_d = 1'b1;
          wd_d   = '0;
          if (acc_last) begin
            grant_d = '0;
            state_d = ARB;
            rr_d    = own_nxt;
          end
        end else begin
          wd_d = wd_q + WW'(1);
          // owner stalled too long: release as if its last pixel went out
          if (wd_d == WW'(TIMEOUT)) begin
            wd_d    = '0;
            grant_d = '0;
            state_d = ARB;
            rr_d    = own_nxt;
            terr_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      rr_q    <= '0;
      grant_q <= '0;
      wd_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      wd_q    <= wd_d;
      x_q     <= x_d;
      y_q     <= y_d;
      c_q     <= c_d;
      plot_q  <= plot_d;
      terr_q  <= terr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.x_out       = x_q;
  assign bus.y_out       = y_q;
  assign bus.colour_out  = c_q;
  assign bus.plot        = plot_q;
  assign bus.busy        = |grant_q;
  assign bus.timeout_err = terr_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter: reset, bursts, round robin,
// stall, watchdog release and reset mid-burst.
module tb_vga_plot_arbiter;
  import snake_pkg::*;

  localparam int NREQ = 3;
  localparam int XW   = 8;
  localparam int YW   = 7;
  localparam int CW   = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  int cnt [NREQ];
  int eg  [10] = '{1, 1, 0, 2, 2, 0, 4, 4, 0, 1};
  int ep  [10] = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0};
  int ex  [10] = '{0, 0, 1, 0, 16, 17, 0, 32, 33, 0};
  logic [NREQ-1:0] acc;

  vga_plot_arbiter_if #(
    .NREQ (NREQ),
    .XW   (XW),
    .YW   (YW),
    .CW   (CW)
  ) bus ();

  vga_plot_arbiter #(
    .NREQ    (NREQ),
    .XW      (XW),
    .YW      (YW),
    .CW      (CW),
    .TIMEOUT (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_px(input int i, input int x, input int y,
                        input int c);
    bus.req_x[i*XW +: XW] = XW'(x);
    bus.req_y[i*YW +: YW] = YW'(y);
    bus.req_c[i*CW +: CW] = CW'(c);
  endtask

  task automatic idle();
    bus.req   = '0;
    bus.last  = '0;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_c = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // reset with random inputs
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.req   = NREQ'($urandom);
      bus.last  = NREQ'($urandom);
      bus.req_x = (NREQ*XW)'($urandom);
      bus.req_y = (NREQ*YW)'($urandom);
      bus.req_c = (NREQ*CW)'($urandom);
      tick();
      chk("rst_grant", bus.grant, 0);
      chk("rst_plot", bus.plot, 0);
    end
    chk("rst_x", bus.x_out, 0);
    chk("rst_y", bus.y_out, 0);
    chk("rst_c", bus.colour_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_terr", bus.timeout_err, 0);
    idle();
    rst = 1'b0;
    tick();
    chk("post_rst_grant", bus.grant, 0);

    // single burst from requester 0
    bus.req = 3'b001;
    set_px(0, 10, 5, 7);
    tick();
    chk("sb_grant", bus.grant, 1);
    chk("sb_busy", bus.busy, 1);
    chk("sb_plot0", bus.plot, 0);
    for (int i = 0; i < 4; i++) begin
      set_px(0, 10 + i, 5, 7);
      bus.last[0] = (i == 3);
      tick();
      chk("sb_plot", bus.plot, 1);
      chk("sb_x", bus.x_out, 10 + i);
      chk("sb_grant_run", bus.grant, (i == 3) ? 0 : 1);
    end
    chk("sb_y", bus.y_out, 5);
    chk("sb_c", bus.colour_out, 7);
    idle();
    tick();
    chk("sb_end_plot", bus.plot, 0);
    chk("sb_hold_x", bus.x_out, 13);
    chk("sb_end_busy", bus.busy, 0);

    // round robin, all three holding 2-pixel bursts
    do_reset();
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    bus.req = 3'b111;
    for (int c = 0; c < 10; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        set_px(i, i*16 + cnt[i], i, i + 1);
        bus.last[i] = (cnt[i] == 1);
      end
      acc = bus.grant & bus.req;
      tick();
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) cnt[i] = cnt[i] ^ 1;
      chk("rr_grant", bus.grant, eg[c]);
      chk("rr_plot", bus.plot, ep[c]);
      if (ep[c] != 0) chk("rr_x", bus.x_out, ex[c]);
    end

    // requester 1 stalls three cycles mid-burst
    do_reset();
    bus.req = 3'b010;
    set_px(1, 20, 9, 2);
    tick();
    chk("st_grant", bus.grant, 2);
    tick();
    chk("st_x20", bus.x_out, 20);
    set_px(1, 21, 9, 2);
    tick();
    chk("st_x21", bus.x_out, 21);
    bus.req = 3'b000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_plot_low", bus.plot, 0);
      chk("st_grant_hold", bus.grant, 2);
      chk("st_terr", bus.timeout_err, 0);
    end
    bus.req = 3'b010;
    set_px(1, 22, 9, 2);
    tick();
    chk("st_x22", bus.x_out, 22);
    chk("st_plot22", bus.plot, 1);
    set_px(1, 23, 9, 2);
    bus.last = 3'b010;
    tick();
    chk("st_x23", bus.x_out, 23);
    chk("st_done", bus.grant, 0);
    chk("st_terr_end", bus.timeout_err, 0);

    // watchdog release, TIMEOUT = 8
    do_reset();
    bus.req = 3'b100;
    tick();
    chk("to_grant", bus.grant, 4);
    bus.req = 3'b011;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 8) begin
        chk("to_hold", bus.grant, 4);
        chk("to_early", bus.timeout_err, 0);
      end else begin
        chk("to_err", bus.timeout_err, 1);
        chk("to_release", bus.grant, 0);
        chk("to_plot", bus.plot, 0);
      end
    end
    tick();
    chk("to_err_pulse", bus.timeout_err, 0);
    chk("to_next_grant", bus.grant, 1);

    // reset during a requester 1 burst
    do_reset();
    bus.req = 3'b010;
    set_px(1, 40, 3, 5);
    tick();
    chk("rm_grant", bus.grant, 2);
    tick();
    chk("rm_x40", bus.x_out, 40);
    set_px(1, 41, 3, 5);
    rst = 1'b1;
    tick();
    chk("rm_plot", bus.plot, 0);
    chk("rm_grant0", bus.grant, 0);
    chk("rm_x", bus.x_out, 0);
    chk("rm_busy", bus.busy, 0);
    rst = 1'b0;
    bus.req = 3'b011;
    tick();
    chk("rm_regrant", bus.grant, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/vga_plot_arbiter.md
# vga_plot_arbiter

- Shares the single VGA framebuffer write port (`x_out`, `y_out`, `colour_out`, `plot`) between independent pixel producers.
- Producers are the screen clear/black fill, the snake logic and the food generator.
- Grants whole bursts (sprite or segment drawings) round-robin, so pixels from different producers never interleave within a burst.
- Sits between the game-logic blocks and the VGA adapter in the snake top level.
- A watchdog frees the port if a granted producer stalls.

## Interface
Parameters:
- `NREQ`, 3, number of requesters (0 = clear, 1 = snake, 2 = food).
- `XW`, 8, x coordinate width.
- `YW`, 7, y coordinate width.
- `CW`, 3, colour width.
- `TIMEOUT`, 255, consecutive granted-but-idle cycles before forced release; ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous active-high reset.
- `req`  in  NREQ  per-requester pixel valid.
- `last`  in  NREQ  marks the final pixel of the requester's burst.
- `req_x`  in  NREQ*XW  packed x coordinates; requester i at `[i*XW +: XW]`.
- `req_y`  in  NREQ*YW  packed y coordinates.
- `req_c`  in  NREQ*CW  packed colours.
- `grant`  out  NREQ  one-hot burst owner; all zero when no burst is active.
- `x_out`  out  XW  registered pixel x to VGA.
- `y_out`  out  YW  registered pixel y.
- `colour_out`  out  CW  registered colour.
- `plot`  out  1  write enable to VGA; one pixel per high cycle.
- `busy`  out  1  high while a burst is granted.
- `timeout_err`  out  1  one-cycle pulse on forced release.

## Operation
- States: ARB, BURST.
- ARB:
  - If `req` is nonzero, pick the first set bit scanning circularly from `rr_ptr`.
  - Register `grant` one-hot and go to BURST.
  - Otherwise stay in ARB with `grant` = 0.
- BURST: accept = `grant[i] & req[i]`.
  - On accept, capture the requester's x, y and colour into the output registers and set `plot` = 1 next cycle.
  - With no accept, `plot` = 0 next cycle.
- Burst end:
  - Occurs on an accept with `last[i]` = 1.
  - Next cycle: state ARB, `grant` = 0, `rr_ptr` = (i+1) mod NREQ.
- Non-owner requesters are ignored in BURST; their `req` must stay held and no pixels are lost.
- Watchdog:
  - Counter clears on every accept and on entry to BURST.
  - It increments each BURST cycle with no accept.
  - When it reaches TIMEOUT: force burst end as above (`rr_ptr` advances), pulse `timeout_err` for 1 cycle, no plot.
- Single-pixel bursts are allowed (`last` = 1 on the first accept).
- `x_out`/`y_out`/`colour_out` hold their last values when `plot` = 0.
- Reset values:
  - state ARB, `rr_ptr` 0, `grant` 0, watchdog 0.
  - `x_out` 0, `y_out` 0, `colour_out` 0, `plot` 0, `busy` 0, `timeout_err` 0.
- Reset mid-burst: the pixel in flight is dropped, all outputs are at reset values after the edge, and arbitration restarts with requester 0 highest.

## Timing
- `req` rises in ARB at cycle t:
  - `grant` high at t+1.
  - First accept at t+1; `plot` for that pixel at t+2.
- Throughput: 1 pixel/cycle within a burst.
- Burst-to-burst gap: one ARB cycle, so the last accept at t gives a new grant at t+2.
- Output latency: exactly 1 cycle from accept to `plot`, for every pixel.
- Arbitration happens only in ARB; simultaneous requests resolve by `rr_ptr` order.
- `busy` equals `|grant`.
- Watchdog width is clog2(TIMEOUT+1) bits; the compare is equality.

## Structure
- Shared package `snake_pkg`:
  - state enum (ARB, BURST).
  - default XW/YW/CW constants and requester index constants CLEAR=0, SNAKE=1, FOOD=2.
- Sub-module `rr_picker`: combinational, takes `req` and `rr_ptr` and returns a one-hot pick plus a valid flag.
- Remaining logic lives in the arbiter: FSM, watchdog, output registers, and burst-end detection.

## Test plan
- Reset: hold `rst` 2 cycles with random inputs → all outputs 0, `grant` = 000 during and after reset.
- Single burst:
  - Stimulus: req0 with pixels x=10..13, y=5, c=3'b111, `last` on the 4th.
  - Response: `grant` = 001 one cycle after `req`; `plot` high 4 consecutive cycles with x=10,11,12,13; `grant` = 000 the cycle after the last accept.
- Round robin:
  - Stimulus: after reset, all three requesters hold 2-pixel bursts.
  - Response: grant order 001, 010, 100, 001; exactly one `plot`=0 ARB cycle between bursts.
- Stall:
  - Stimulus: requester 1 drops `req` for 3 cycles mid-burst.
  - Response: `plot` low for those 3 cycles, `grant` stays 010, remaining pixels delivered in order, no `timeout_err`.
- Timeout:
  - Stimulus: TIMEOUT=8; requester 2 granted, then `req` low for 8 cycles.
  - Response: `timeout_err` high for 1 cycle, `grant` → 000, next pending requester 0 granted before 1.
- Reset mid-burst:
  - Stimulus: assert `rst` during a requester 1 burst.
  - Response: the next cycle shows `plot` 0 and `grant` 0; after release with req1 and req0 both high, requester 0 is granted first.
